// File: rtl/bus_pkg.sv
// Shared types and helpers for the ADS serial-bus arbiter.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_CONNECT = 3'd2,
    ST_BUSY    = 3'd3,
    ST_SPLIT   = 3'd4
  } state_e;

  // Ceiling log2, floored at 1 so the result can always size a vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;
  logic [W:0]   pos;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    found = |req;
    idx   = '0;
    pos   = '0;
    // Walk offsets from the far end so the nearest request to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = {1'b0, ptr} + (W+1)'(k);
        if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
        idx = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin serial-bus arbiter/interconnect with decode errors and split-transaction preemption.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int  NUM_MASTERS   = 2,
  parameter int  NUM_SLAVES    = 3,
  parameter int  SLV_ADDR_BITS = 2,
  parameter int  SPLIT_TIMEOUT = 12,
  localparam int MW            = bus_pkg::clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_data_out,
  output logic [NUM_MASTERS-1:0] m_valid_in,
  output logic [NUM_MASTERS-1:0] m_available,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  input  logic [NUM_SLAVES-1:0]  s_data_in,
  input  logic [NUM_SLAVES-1:0]  s_valid_out,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  output logic [NUM_SLAVES-1:0]  s_valid,
  output logic [NUM_SLAVES-1:0]  bus_ready,
  output logic [2:0]             state,
  output logic [MW-1:0]          grant,
  output logic                   connected,
  output logic                   err_decode
);

  localparam int BW = bus_pkg::clog2(SLV_ADDR_BITS + 1);
  localparam int CW = bus_pkg::clog2(SPLIT_TIMEOUT + 1);
  localparam logic [MW-1:0]          LAST_MASTER = MW'(NUM_MASTERS - 1);
  localparam logic [BW-1:0]          LAST_BIT    = BW'(SLV_ADDR_BITS - 1);
  localparam logic [CW-1:0]          TIMEOUT     = CW'(SPLIT_TIMEOUT);
  localparam logic [SLV_ADDR_BITS:0] SLAVE_LIMIT = (SLV_ADDR_BITS+1)'(NUM_SLAVES);

  state_e                   state_q, state_d;
  logic [MW-1:0]            grant_q, grant_d;
  logic [MW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [SLV_ADDR_BITS-1:0] addr_q, addr_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]            wait_q, wait_d;
  logic                     conn_valid_q, conn_valid_d;
  logic [SLV_ADDR_BITS-1:0] conn_slave_q, conn_slave_d;
  logic                     err_d;

  logic [NUM_MASTERS-1:0]   grant_onehot, pick_req;
  logic [MW-1:0]            grant_inc, pick_ptr, pick_idx;
  logic                     pick_found, sel_ready, others_req;
  logic                     in_wait_q, in_wait_d;
  logic [SLV_ADDR_BITS:0]   addr_shifted;
  logic                     conn_ready, conn_dout, conn_vout;

  always_comb begin
    grant_onehot = '0;
    for (int m = 0; m < NUM_MASTERS; m++) grant_onehot[m] = (grant_q == MW'(m));
    sel_ready = 1'b0;
    for (int s = 0; s < NUM_SLAVES; s++)
      if (addr_q == SLV_ADDR_BITS'(s)) sel_ready = s_ready[s];
  end

  assign grant_inc    = (grant_q == LAST_MASTER) ? '0 : grant_q + 1'b1;
  assign others_req   = |(m_request & ~grant_onehot);
  assign addr_shifted = {addr_q, m_address[grant_q]};

  // One picker serves both the IDLE arbitration and the SPLIT hand-over.
  assign pick_req = (state_q == ST_SPLIT) ? (m_request & ~grant_onehot)
                                          : (m_request & m_address_valid);
  assign pick_ptr = (state_q == ST_SPLIT) ? grant_inc : rr_ptr_q;

  rr_picker #(.N(NUM_MASTERS), .W(MW)) u_picker (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    addr_d       = addr_q;
    bit_cnt_d    = bit_cnt_q;
    conn_valid_d = conn_valid_q;
    conn_slave_d = conn_slave_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: if (pick_found) begin
        grant_d   = pick_idx;
        addr_d    = '0;
        bit_cnt_d = '0;
        state_d   = ST_ADDR;
      end
      ST_ADDR: if (m_valid[grant_q]) begin
        addr_d = addr_shifted[SLV_ADDR_BITS-1:0];
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = ST_CONNECT;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_CONNECT: begin
        if ({1'b0, addr_q} >= SLAVE_LIMIT) begin
          err_d    = 1'b1;
          rr_ptr_d = grant_inc;
          state_d  = ST_IDLE;
        end else if (sel_ready) begin
          conn_valid_d = 1'b1;
          conn_slave_d = addr_q;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!m_request[grant_q]) begin
          conn_valid_d = 1'b0;
          rr_ptr_d     = grant_inc;
          state_d      = ST_IDLE;
        end else if (wait_q >= TIMEOUT && others_req) begin
          state_d = ST_SPLIT;
        end else if (m_address_valid[grant_q]) begin
          conn_valid_d = 1'b0;
          addr_d       = '0;
          bit_cnt_d    = '0;
          state_d      = ST_ADDR;
        end
      end
      ST_SPLIT: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          conn_valid_d = 1'b0;
          addr_d       = '0;
          bit_cnt_d    = '0;
          state_d      = ST_ADDR;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        conn_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // Slave-wait counter only survives while staying inside CONNECT/BUSY.
    in_wait_q = (state_q == ST_CONNECT) || (state_q == ST_BUSY);
    in_wait_d = (state_d == ST_CONNECT) || (state_d == ST_BUSY);
    wait_d    = '0;
    if (in_wait_q && in_wait_d && !sel_ready)
      wait_d = (wait_q >= TIMEOUT) ? wait_q : wait_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      addr_q       <= '0;
      bit_cnt_q    <= '0;
      wait_q       <= '0;
      conn_valid_q <= 1'b0;
      conn_slave_q <= '0;
      err_decode   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      addr_q       <= addr_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_q       <= wait_d;
      conn_valid_q <= conn_valid_d;
      conn_slave_q <= conn_slave_d;
      err_decode   <= err_d;
    end
  end

  // Routing is purely combinational off the registered connection.
  always_comb begin
    s_address  = '0;
    s_data     = '0;
    s_write_en = '0;
    s_valid    = '0;
    bus_ready  = '1;
    conn_ready = 1'b0;
    conn_dout  = 1'b0;
    conn_vout  = 1'b0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (conn_valid_q && conn_slave_q == SLV_ADDR_BITS'(s)) begin
        s_address[s]  = m_address[grant_q];
        s_data[s]     = m_data[grant_q];
        s_write_en[s] = m_write_en[grant_q];
        s_valid[s]    = m_valid[grant_q] && (state_q != ST_ADDR);
        conn_ready    = s_ready[s];
        conn_dout     = s_data_in[s];
        conn_vout     = s_valid_out[s];
      end else if (conn_valid_q) begin
        bus_ready[s] = 1'b0;
      end
    end
    for (int m = 0; m < NUM_MASTERS; m++) begin
      m_ready[m]     = conn_valid_q && grant_onehot[m] && conn_ready;
      m_data_out[m]  = conn_valid_q && grant_onehot[m] && conn_dout;
      m_valid_in[m]  = conn_valid_q && grant_onehot[m] && conn_vout;
      m_available[m] = (state_q == ST_IDLE) || grant_onehot[m];
    end
  end

  assign state     = state_q;
  assign grant     = grant_q;
  assign connected = conn_valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench: default 2x3 arbiter plus a 4x5 / 3-bit-address instance.
module tb_bus_arbiter_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance (2 masters, 3 slaves, 2 address bits)
  logic [1:0] m_request, m_address_valid, m_address, m_data, m_valid, m_write_en;
  logic [1:0] m_ready, m_data_out, m_valid_in, m_available;
  logic [2:0] s_ready, s_data_in, s_valid_out;
  logic [2:0] s_address, s_data, s_write_en, s_valid, bus_ready;
  logic [2:0] state;
  logic [0:0] grant;
  logic       connected, err_decode;

  // Wide instance (4 masters, 5 slaves, 3 address bits)
  logic [3:0] b_m_request, b_m_address_valid, b_m_address, b_m_data, b_m_valid, b_m_write_en;
  logic [3:0] b_m_ready, b_m_data_out, b_m_valid_in, b_m_available;
  logic [4:0] b_s_ready, b_s_data_in, b_s_valid_out;
  logic [4:0] b_s_address, b_s_data, b_s_write_en, b_s_valid, b_bus_ready;
  logic [2:0] b_state;
  logic [1:0] b_grant;
  logic       b_connected, b_err_decode;

  bus_arbiter_rr dut (
    .clk(clk), .reset(reset),
    .m_request(m_request), .m_address_valid(m_address_valid), .m_address(m_address),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en),
    .m_ready(m_ready), .m_data_out(m_data_out), .m_valid_in(m_valid_in),
    .m_available(m_available),
    .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out),
    .s_address(s_address), .s_data(s_data), .s_write_en(s_write_en), .s_valid(s_valid),
    .bus_ready(bus_ready), .state(state), .grant(grant), .connected(connected),
    .err_decode(err_decode)
  );

  bus_arbiter_rr #(.NUM_MASTERS(4), .NUM_SLAVES(5), .SLV_ADDR_BITS(3)) dut_wide (
    .clk(clk), .reset(reset),
    .m_request(b_m_request), .m_address_valid(b_m_address_valid), .m_address(b_m_address),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_write_en(b_m_write_en),
    .m_ready(b_m_ready), .m_data_out(b_m_data_out), .m_valid_in(b_m_valid_in),
    .m_available(b_m_available),
    .s_ready(b_s_ready), .s_data_in(b_s_data_in), .s_valid_out(b_s_valid_out),
    .s_address(b_s_address), .s_data(b_s_data), .s_write_en(b_s_write_en), .s_valid(b_s_valid),
    .bus_ready(b_bus_ready), .state(b_state), .grant(b_grant), .connected(b_connected),
    .err_decode(b_err_decode)
  );

  typedef struct {
    logic        ma, md, mv, mwe, sr, sd, sv;
    logic [17:0] exp;  // {s_address, s_data, s_valid, s_write_en, m_ready, m_data_out, m_valid_in}
  } route_vec_t;

  route_vec_t  vecs[6];
  logic [17:0] route_q[$];
  int          grant_exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m_request = '0; m_address_valid = '0; m_address = '0;
    m_data = '0; m_valid = '0; m_write_en = '0;
    s_ready = '0; s_data_in = '0; s_valid_out = '0;
    b_m_request = '0; b_m_address_valid = '0; b_m_address = '0;
    b_m_data = '0; b_m_valid = '0; b_m_write_en = '0;
    b_s_ready = '0; b_s_data_in = '0; b_s_valid_out = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
  endtask

  // Request the default bus for master m and take the grant edge.
  task automatic start1(input int m);
    m_request[m]       = 1'b1;
    m_address_valid[m] = 1'b1;
    step();
    m_address_valid[m] = 1'b0;
  endtask

  // Shift a 2-bit slave address MSB first; returns with the FSM in CONNECT.
  task automatic shift1(input int m, input logic [1:0] a);
    m_valid[m]   = 1'b1;
    m_address[m] = a[1];
    step();
    m_address[m] = a[0];
    step();
    m_valid[m]   = 1'b0;
    m_address[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {3'b000, 3'b100, 3'b100, 3'b100, 2'b01, 2'b00, 2'b00}};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {3'b100, 3'b000, 3'b100, 3'b000, 2'b01, 2'b01, 2'b01}};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {3'b100, 3'b100, 3'b000, 3'b000, 2'b00, 2'b01, 2'b00}};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {3'b000, 3'b000, 3'b000, 3'b100, 2'b01, 2'b00, 2'b01}};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {3'b100, 3'b100, 3'b100, 3'b100, 2'b00, 2'b01, 2'b01}};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {3'b000, 3'b000, 3'b000, 3'b000, 2'b01, 2'b00, 2'b00}};

    // Reset values, held while reset is low
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst state", state, 3'd0);
    check("rst grant", grant, 1'b0);
    check("rst connected", connected, 1'b0);
    check("rst err", err_decode, 1'b0);
    check("rst slave outs", {s_address, s_data, s_write_en, s_valid}, 12'h000);
    check("rst bus_ready", bus_ready, 3'b111);
    check("rst master outs", {m_ready, m_data_out, m_valid_in}, 6'b0);
    check("rst m_available", m_available, 2'b11);
    check("rst wide bus_ready", b_bus_ready, 5'b11111);
    check("rst wide m_available", b_m_available, 4'b1111);
    #1 reset = 1'b1;
    step();
    check("idle no request", state, 3'd0);

    // M0 addresses S2 (bits 1,0): ADDR at cycle 1, CONNECT at 3, BUSY at 4
    s_ready = 3'b100;
    start1(0);
    check("t1 addr state", state, 3'd1);
    check("t1 grant", grant, 1'b0);
    check("t1 m_available", m_available, 2'b01);
    m_valid[0] = 1'b1; m_address[0] = 1'b1;
    step();
    check("t1 addr bit1 state", state, 3'd1);
    check("t1 no forward in addr", s_address, 3'b000);
    m_address[0] = 1'b0;
    step();
    m_valid[0] = 1'b0;
    check("t1 connect state", state, 3'd2);
    check("t1 connect not connected", connected, 1'b0);
    step();
    check("t1 busy state", state, 3'd3);
    check("t1 connected", connected, 1'b1);
    check("t1 bus_ready", bus_ready, 3'b100);

    // Routing table on the live M0<->S2 connection, with noise on the other lanes
    m_data[1] = 1'b1; m_valid[1] = 1'b1; m_write_en[1] = 1'b1; m_address[1] = 1'b1;
    s_ready[1:0] = 2'b11; s_data_in[1:0] = 2'b11; s_valid_out[1:0] = 2'b11;
    for (int i = 0; i < 6; i++) begin
      m_address[0] = vecs[i].ma; m_data[0] = vecs[i].md;
      m_valid[0] = vecs[i].mv; m_write_en[0] = vecs[i].mwe;
      s_ready[2] = vecs[i].sr; s_data_in[2] = vecs[i].sd; s_valid_out[2] = vecs[i].sv;
      route_q.push_back(vecs[i].exp);
      #1;
      check($sformatf("route[%0d]", i),
            {s_address, s_data, s_valid, s_write_en, m_ready, m_data_out, m_valid_in},
            route_q.pop_front());
      step();
    end
    check("t1 still busy", state, 3'd3);

    // Release: IDLE and no forwarding on the next edge
    clear_inputs();
    s_ready = 3'b100;
    m_data[0] = 1'b1; m_valid[0] = 1'b1;
    step();
    check("release state", state, 3'd0);
    check("release slave outs", {s_address, s_data, s_write_en, s_valid}, 12'h000);
    check("release bus_ready", bus_ready, 3'b111);
    check("release connected", connected, 1'b0);

    // Simultaneous requests from a fresh reset: grant order M0, M1, M0
    do_reset();
    s_ready = 3'b111;
    grant_exp_q.push_back(0);
    grant_exp_q.push_back(1);
    grant_exp_q.push_back(0);
    for (int r = 0; r < 3; r++) begin
      int w;
      m_request = 2'b11; m_address_valid = 2'b11;
      step();
      m_address_valid = 2'b00;
      w = grant_exp_q.pop_front();
      check($sformatf("rr grant[%0d]", r), grant, w);
      shift1(w, 2'b00);
      step();
      check($sformatf("rr busy[%0d]", r), state, 3'd3);
      m_request = 2'b00;
      step();
      check($sformatf("rr idle[%0d]", r), state, 3'd0);
    end

    // Out-of-range address 2'b11 -> single err_decode pulse, back to IDLE
    clear_inputs();
    s_ready = 3'b111;
    start1(0);
    shift1(0, 2'b11);
    check("err connect state", state, 3'd2);
    check("err not yet", err_decode, 1'b0);
    m_request[0] = 1'b0;
    step();
    check("err pulse", err_decode, 1'b1);
    check("err idle", state, 3'd0);
    check("err slave outs", {s_address, s_data, s_write_en, s_valid}, 12'h000);
    check("err not connected", connected, 1'b0);
    step();
    check("err pulse ends", err_decode, 1'b0);

    // Split: M0 on S1, slave stalls 12 cycles while M1 requests
    clear_inputs();
    s_ready = 3'b010;
    start1(0);
    shift1(0, 2'b01);
    step();
    check("split busy", state, 3'd3);
    check("split bus_ready", bus_ready, 3'b010);
    m_request[1] = 1'b1;
    s_ready = 3'b000;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("split wait[%0d]", i), state, 3'd3);
    end
    step();
    check("split state", state, 3'd4);
    step();
    check("split addr state", state, 3'd1);
    check("split new grant", grant, 1'b1);
    check("split dropped", connected, 1'b0);
    check("split m_available", m_available, 2'b10);
    s_ready = 3'b001;
    shift1(1, 2'b00);
    step();
    check("split m1 busy", state, 3'd3);
    check("split m1 bus_ready", bus_ready, 3'b001);
    m_request = 2'b00;
    step();
    check("split m1 release", state, 3'd0);

    // Same stall with nobody else requesting: M0 keeps the bus
    clear_inputs();
    s_ready = 3'b010;
    start1(0);
    shift1(0, 2'b01);
    step();
    s_ready = 3'b000;
    repeat (20) step();
    check("no split state", state, 3'd3);
    check("no split connected", connected, 1'b1);
    m_request[0] = 1'b0;
    step();
    check("no split release", state, 3'd0);

    // Asynchronous reset mid-BUSY drops forwarding before the next edge
    clear_inputs();
    s_ready = 3'b100;
    start1(0);
    shift1(0, 2'b10);
    step();
    m_data[0] = 1'b1; m_valid[0] = 1'b1; m_write_en[0] = 1'b1;
    #1;
    check("arst pre forward", {s_data, s_valid, s_write_en}, 9'b100_100_100);
    #1 reset = 1'b0;
    #1;
    check("arst slave outs", {s_address, s_data, s_write_en, s_valid}, 12'h000);
    check("arst bus_ready", bus_ready, 3'b111);
    check("arst state", state, 3'd0);
    check("arst master outs", {m_ready, connected}, 3'b000);
    clear_inputs();
    #1 reset = 1'b1;
    step();
    check("arst idle after", state, 3'd0);

    // Wide configuration: M3 addresses slave 4 (bits 1,0,0)
    b_s_ready = 5'b10000;
    b_m_request[3] = 1'b1; b_m_address_valid[3] = 1'b1;
    step();
    b_m_address_valid[3] = 1'b0;
    check("wide grant", b_grant, 2'd3);
    check("wide addr state", b_state, 3'd1);
    b_m_valid[3] = 1'b1;
    b_m_address[3] = 1'b1; step();
    b_m_address[3] = 1'b0; step();
    step();
    b_m_valid[3] = 1'b0;
    check("wide connect state", b_state, 3'd2);
    step();
    check("wide busy state", b_state, 3'd3);
    b_m_data = 4'b1111; b_m_valid = 4'b1111; b_m_write_en = 4'b1111; b_m_address = 4'b0111;
    b_s_data_in = 5'b11111; b_s_valid_out = 5'b10000;
    #1;
    check("wide s_data", b_s_data, 5'b10000);
    check("wide s_valid", b_s_valid, 5'b10000);
    check("wide s_write_en", b_s_write_en, 5'b10000);
    check("wide s_address", b_s_address, 5'b00000);
    check("wide bus_ready", b_bus_ready, 5'b10000);
    check("wide master outs", {b_m_ready, b_m_data_out, b_m_valid_in}, 12'b1000_1000_1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
